fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling FIFO between the PC/instruction-fetch stage and the decode stage. Each entry holds one fetched {pc, instr} pair plus a misalignment tag, and the queue presents the oldest entry to decode through a valid/ready handshake. On a control-flow redirect, a flush discards every queued entry in one cycle and counts them. It back-pressures fetch when full.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- NOP, 32'h00000013, instruction word driven on out_instr when the queue is empty

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, synchronous, active-high; clock clk
- in_valid  in  1  fetch presents a pair this cycle
- in_pc  in  32  PC of the fetched instruction
- in_instr  in  32  fetched instruction word
- in_ready  out  1  queue can accept a push this cycle
- out_valid  out  1  head entry valid
- out_pc  out  32  head entry PC
- out_instr  out  32  head entry instruction
- out_misalign  out  1  head entry had in_pc[1:0] != 0
- out_ready  in  1  decode consumes the head this cycle
- flush  in  1  redirect; discard all entries
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- drop_cnt  out  16  saturating count of entries discarded by flush

## Operation
- Storage: circular array of DEPTH entries {pc[31:0], instr[31:0], misalign}. Write pointer, read pointer and count are registered. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The storage array is not reset.
- Push: in_valid && in_ready. Writes {in_pc, in_instr, |in_pc[1:0]} at wr_ptr, then wr_ptr+1.
- Pop: out_valid && out_ready. Advances rd_ptr by 1.
- in_ready = (count != DEPTH). It depends on registered state only. There is no full-queue pass-through: a pop in the same cycle does not raise in_ready.
- out_valid = (count != 0). out_pc, out_instr and out_misalign read combinationally from entry rd_ptr.
- When empty, the outputs are forced: out_pc=0, out_instr=NOP, out_misalign=0.
- No bypass: a pushed entry is never visible on out_* in the cycle it is pushed.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged, both pointers advance
- Flush has highest priority below reset. In the flush cycle:
  - wr_ptr, rd_ptr and count go to 0 at the edge.
  - Any push or pop handshake in that cycle has no effect on the queue.
  - drop_cnt += count + (in_valid && in_ready), saturating at 16'hFFFF.
- Reset overrides flush. On reset: wr_ptr=0, rd_ptr=0, count=0, drop_cnt=0. Pushes and pops during reset are ignored.
- Output values during and after reset: out_valid=0, in_ready=1, out_pc=0, out_instr=NOP, out_misalign=0.

## Timing
- Push-to-visible latency is 1 cycle: a push at edge N gives out_valid=1 after edge N.
- Sustained throughput is 1 push and 1 pop per cycle when 0 < count < DEPTH.
- Full (count==DEPTH): in_ready=0. Fetch must hold its PC; a pop at edge N gives in_ready=1 after edge N.
- Empty (count==0): a pop attempt is ignored (out_valid=0 gates it).
- Wrap-around: pointer DEPTH−1 → 0 with no bubble.
- Flush at edge N: out_valid=0 and count=0 after N. The first post-flush push is accepted in cycle N+1 and visible after edge N+1.
- Reset asserted mid-stream: the state listed under Operation holds after the first reset edge. Entries present before reset are never presented again.
- drop_cnt updates at the flush edge and holds at 16'hFFFF once saturated.

## Test plan
- Reset, then idle → out_valid=0, in_ready=1, out_instr=32'h00000013, count=0, drop_cnt=0.
- Push pc 0x0,0x4,0x8,0xC with out_ready=0 → count=4, in_ready=0. A fifth push of pc 0x10 is refused. Then pop 4 with out_ready=1 → out_pc sequence 0x0,0x4,0x8,0xC, one per cycle.
- Continuous push+pop for 10 cycles starting with count=2 → count stays 2, and out_pc follows in_pc with a 2-entry lag across the pointer wrap.
- Fill 3 entries, then assert flush together with a push of pc 0x40 → count=0, out_valid=0, drop_cnt=4. Next cycle push pc 0x100 → out_pc=0x100 one cycle later.
- Push in_pc=0x6 → out_misalign=1 at the head. Pop it, then push pc 0x8 → out_misalign=0.
- Fill 3 entries, assert reset for 1 cycle with in_valid=1 → count=0, out_valid=0, drop_cnt=0. No pre-reset entry appears afterwards.

Source files
------------

// File: rtl/fetch_queue.sv
// Decoupling FIFO between instruction fetch and decode: holds {pc, instr, misalign}
// entries, presents the oldest through valid/ready, and flushes in one cycle on redirect.
module fetch_queue #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_misalign,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic [16:0]     drop_sum;
  logic [15:0]     drop_next;

  // Ready depends only on registered occupancy; a same-cycle pop never frees a slot early.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head         = mem[rd_ptr];
  assign out_pc       = out_valid ? head.pc       : '0;
  assign out_instr    = out_valid ? head.instr    : NOP;
  assign out_misalign = out_valid ? head.misalign : 1'b0;

  // A push accepted in the flush cycle is discarded too, so it counts as dropped.
  always_comb begin
    drop_sum  = {1'b0, drop_cnt} + 17'(count) + 17'(push);
    drop_next = drop_sum[16] ? '1 : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem[wr_ptr] <= '{pc: in_pc, instr: in_instr, misalign: |in_pc[1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= drop_next;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misalign;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;
  logic [15:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  ent_t mq[$];
  int   mdrop = 0;

  fetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_misalign(out_misalign), .out_ready(out_ready),
    .flush(flush), .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference behaviour at a rising edge, from the current input values.
  task automatic model_step();
    bit can_push;
    int d;
    can_push = in_valid && (mq.size() < DEPTH);
    if (reset) begin
      mq.delete();
      mdrop = 0;
    end else if (flush) begin
      d = mdrop + mq.size() + (can_push ? 1 : 0);
      mdrop = (d > 65535) ? 65535 : d;
      mq.delete();
    end else begin
      if (out_ready && mq.size() > 0) void'(mq.pop_front());
      if (can_push) mq.push_back('{pc: in_pc, instr: in_instr, mis: (in_pc % 4) != 0});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    n_cmp++; if (out_instr !== 32'h00000013) begin n_err++; $display("FAIL reset_out_instr: got %h expected 00000013", out_instr); end
    n_cmp++; if (out_pc !== 32'h0 || out_misalign !== 1'b0) begin n_err++; $display("FAIL reset_out_pc: got %h/%0b expected 0/0", out_pc, out_misalign); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pc = 32'(i * 4); in_instr = $urandom; tick();
    end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d expected 4", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %0b expected 0", in_ready); end
    in_pc = 32'h10; in_instr = $urandom; tick();
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL refused_push_count: got %0d expected 4", count); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4)) begin n_err++; $display("FAIL drain_pc[%0d]: got %0b/%h expected 1/%h", i, out_valid, out_pc, 32'(i * 4)); end
      n_cmp++; if (out_instr !== mq[0].instr) begin n_err++; $display("FAIL drain_instr[%0d]: got %h expected %h", i, out_instr, mq[0].instr); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0 || out_instr !== NOP) begin n_err++; $display("FAIL drained_empty: got %0b/%0d/%h expected 0/0/%h", out_valid, count, out_instr, NOP); end
    tick();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL empty_pop_ignored: got %0d expected 0", count); end
  endtask

  task automatic test_stream();
    logic [31:0] base;
    base = 32'h1000;
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_pc = base + 32'(4 * k); in_instr = $urandom; tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_pc = base + 32'(4 * (k + 2)); in_instr = $urandom;
      n_cmp++; if (out_pc !== base + 32'(4 * k)) begin n_err++; $display("FAIL stream_lag[%0d]: got %h expected %h", k, out_pc, base + 32'(4 * k)); end
      tick();
      n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL stream_count[%0d]: got %0d expected 2", k, count); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_pc = 32'h20 + 32'(4 * k); in_instr = $urandom; tick();
    end
    flush = 1'b1; in_pc = 32'h40; tick();
    flush = 1'b0;
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %0d/%0b expected 0/0", count, out_valid); end
    n_cmp++; if (drop_cnt !== 16'd4) begin n_err++; $display("FAIL flush_drop4: got %0d expected 4", drop_cnt); end
    in_pc = 32'h100; in_instr = $urandom; tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin n_err++; $display("FAIL post_flush_push: got %0b/%h expected 1/100", out_valid, out_pc); end
    // one entry queued, pop attempted during flush: drop 1 more
    flush = 1'b1; out_ready = 1'b1; tick();
    flush = 1'b0; out_ready = 1'b0;
    n_cmp++; if (drop_cnt !== 16'd5) begin n_err++; $display("FAIL flush_with_pop: got %0d expected 5", drop_cnt); end
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_pc = 32'h300 + 32'(4 * k); in_instr = $urandom; tick();
    end
    flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (drop_cnt !== 16'd9) begin n_err++; $display("FAIL flush_full_no_push: got %0d expected 9", drop_cnt); end
  endtask

  task automatic test_misalign();
    do_reset();
    in_valid = 1'b1; in_pc = 32'h6; in_instr = $urandom; tick();
    in_valid = 1'b0;
    n_cmp++; if (out_misalign !== 1'b1) begin n_err++; $display("FAIL misalign_set: got %0b expected 1", out_misalign); end
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h8; tick();
    in_valid = 1'b0;
    n_cmp++; if (out_misalign !== 1'b0 || out_pc !== 32'h8) begin n_err++; $display("FAIL misalign_clear: got %0b/%h expected 0/8", out_misalign, out_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_pc = 32'h500 + 32'(4 * k); in_instr = $urandom; tick();
    end
    flush = 1'b1; tick();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_pc = 32'h600 + 32'(4 * k); in_instr = $urandom; tick();
    end
    reset = 1'b1; flush = 1'b1; tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL midreset_state: got %0d/%0b/%0b expected 0/0/1", count, out_valid, in_ready); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL midreset_drop: got %0d expected 0", drop_cnt); end
    out_ready = 1'b1; tick(); tick();
    n_cmp++; if (out_valid !== 1'b0 || out_instr !== NOP) begin n_err++; $display("FAIL midreset_stale: got %0b/%h expected 0/%h", out_valid, out_instr, NOP); end
    in_valid = 1'b1; in_pc = 32'h700; out_ready = 1'b0; tick();
    in_valid = 1'b0;
    n_cmp++; if (out_pc !== 32'h700 || count !== 3'd1) begin n_err++; $display("FAIL midreset_new: got %h/%0d expected 700/1", out_pc, count); end
  endtask

  task automatic test_random();
    logic        e_valid, e_mis;
    logic [31:0] e_pc, e_instr;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 50);
      flush     = ($urandom_range(0, 99) < 4);
      reset     = ($urandom_range(0, 199) < 1);
      in_pc     = $urandom;
      in_instr  = $urandom;
      tick();
      e_valid = (mq.size() != 0);
      e_pc    = e_valid ? mq[0].pc : 32'h0;
      e_instr = e_valid ? mq[0].instr : NOP;
      e_mis   = e_valid ? mq[0].mis : 1'b0;
      n_cmp++; if (count !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", c, count, mq.size()); end
      n_cmp++; if (out_valid !== e_valid || in_ready !== (mq.size() < DEPTH)) begin n_err++; $display("FAIL rnd_hs[%0d]: got %0b/%0b expected %0b/%0b", c, out_valid, in_ready, e_valid, mq.size() < DEPTH); end
      n_cmp++; if (out_pc !== e_pc || out_instr !== e_instr || out_misalign !== e_mis) begin n_err++; $display("FAIL rnd_head[%0d]: got %h/%h/%0b expected %h/%h/%0b", c, out_pc, out_instr, out_misalign, e_pc, e_instr, e_mis); end
      n_cmp++; if (drop_cnt !== 16'(mdrop)) begin n_err++; $display("FAIL rnd_drop[%0d]: got %0d expected %0d", c, drop_cnt, mdrop); end
    end
    idle_inputs();
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    test_reset();
    test_fill_drain();
    test_stream();
    test_flush();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
